// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_defs_pkg : shared CPU widths, reset vector and fetch entry type |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
package cpu_defs_pkg;

  localparam int XLEN = 32;
  localparam int INST_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | inst_fetch_unit_if : ROM, decode and redirect signals of fetch      |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
interface inst_fetch_unit_if
  import cpu_defs_pkg::*;
#(
  parameter int ADDR_W = XLEN,
  parameter int DATA_W = INST_W
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_rdata, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_rdata, inst_ready, redirect_valid, redirect_pc
  );

endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_queue : DEPTH-entry synchronous FIFO of fetch entries         |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module fetch_queue
  import cpu_defs_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type ENTRY_T = fetch_entry_t
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   i_push,
  input  wire ENTRY_T                 i_push_data,
  input  wire logic                   i_pop,
  input  wire logic                   i_flush,
  output logic [$clog2(DEPTH):0]      o_count,
  output ENTRY_T                      o_head
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0] c_full = (c_ptr_w + 1)'(DEPTH);

  ENTRY_T             r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign w_do_push = i_push && (r_count != c_full);
  assign w_do_pop  = i_pop && (r_count != '0);

  // Flush drops every entry, including any push arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads as zero until first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | inst_fetch_unit : PC, ROM request issue, redirect and prefetch queue|
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module inst_fetch_unit
  import cpu_defs_pkg::*;
#(
  parameter int                ADDR_W   = XLEN,
  parameter int                DATA_W   = INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_defs_pkg::RESET_PC),
  parameter int                DEPTH    = 4
) (
  input wire logic          clk,
  input wire logic          rst,
  inst_fetch_unit_if.master bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  localparam int c_cnt_w = $clog2(DEPTH) + 1;
  localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
  localparam logic [ADDR_W-1:0]  c_pc_step = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0]  c_align   = ~ADDR_W'(3);

  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  r_inflight_pc;
  logic               r_inflight;
  logic               r_kill;
  logic [c_cnt_w-1:0] w_count;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  entry_t             w_push_entry;
  entry_t             w_head;

  // Credit check ignores a same-cycle pop, so the queue can never overflow.
  assign w_issue = !rst && !bus.redirect_valid &&
                   ((w_count + c_cnt_w'(r_inflight)) < c_depth);
  assign w_push  = r_inflight && !r_kill;
  assign w_pop   = bus.inst_valid && bus.inst_ready;

  assign w_push_entry.pc   = r_inflight_pc;
  assign w_push_entry.inst = bus.imem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= '0;
      r_inflight    <= 1'b0;
      r_kill        <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_kill     <= bus.redirect_valid && r_inflight;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + c_pc_step;
      end else if (bus.redirect_valid) begin
        r_fetch_pc <= bus.redirect_pc & c_align;
      end
    end
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .ENTRY_T (entry_t)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_flush     (bus.redirect_valid),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  assign bus.imem_req   = w_issue;
  assign bus.imem_addr  = r_fetch_pc;
  assign bus.inst_valid = (w_count != '0);
  assign bus.inst_data  = w_head.inst;
  assign bus.inst_pc    = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_inst_fetch_unit : directed self-checking bench for fetch unit    |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_inst_fetch_unit;

  localparam logic [31:0] c_mask = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  inst_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  inst_fetch_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // ROM: data for a request appears one cycle later.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= bus.imem_addr ^ c_mask;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Redirect at R, then check R+1 address, R+2 next address, R+3 head.
  task automatic redirect(input logic [31:0] pc, input bit chk_head, input logic [31:0] head_pc);
    logic [31:0] al;
    al = pc & 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    #1;
    chk("redir_noreq", bus.imem_req, 1'b0);
    if (chk_head) begin
      chk("redir_head_valid", bus.inst_valid, 1'b1);
      chk("redir_head_pc", bus.inst_pc, head_pc);
    end
    step();
    bus.redirect_valid = 1'b0;
    #1;
    chk("redir_addr", bus.imem_addr, al);
    chk("redir_flushed", bus.inst_valid, 1'b0);
    step();
    chk("redir_addr2", bus.imem_addr, al + 32'd4);
    chk("redir_gap", bus.inst_valid, 1'b0);
    step();
    chk("redir_valid", bus.inst_valid, 1'b1);
    chk("redir_pc", bus.inst_pc, al);
    chk("redir_data", bus.inst_data, al ^ c_mask);
  endtask

  initial begin
    rst                = 1'b1;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_valid", bus.inst_valid, 1'b0);
    chk("rst_data", bus.inst_data, 32'h0);
    chk("rst_pc", bus.inst_pc, 32'h0);

    // Streaming from reset
    rst            = 1'b0;
    bus.inst_ready = 1'b1;
    #1;
    chk("s_req0", bus.imem_req, 1'b1);
    chk("s_addr0", bus.imem_addr, 32'h0);
    chk("s_valid0", bus.inst_valid, 1'b0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("s_req", bus.imem_req, 1'b1);
      chk("s_addr", bus.imem_addr, 32'(4 * i));
      if (i >= 2) begin
        chk("s_valid", bus.inst_valid, 1'b1);
        chk("s_pc", bus.inst_pc, 32'(4 * (i - 2)));
        chk("s_data", bus.inst_data, 32'(4 * (i - 2)) ^ c_mask);
      end else begin
        chk("s_valid1", bus.inst_valid, 1'b0);
      end
    end

    // Redirect while a fetch is in flight; head 0x18 is on the bus at R
    redirect(32'h0000_0100, 1'b1, 32'h0000_0018);

    // Redirect together with a handshake on pc 0x8
    redirect(32'h0000_0000, 1'b0, 32'h0);
    step();
    chk("hs_pc4", bus.inst_pc, 32'h4);
    redirect(32'h0000_0200, 1'b1, 32'h0000_0008);
    step();
    chk("hs_next", bus.inst_pc, 32'h0000_0204);

    // Back-to-back redirects: the last one wins
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0300;
    step();
    bus.redirect_pc = 32'h0000_0400;
    #1;
    chk("b2b_noreq", bus.imem_req, 1'b0);
    step();
    bus.redirect_valid = 1'b0;
    #1;
    chk("b2b_addr", bus.imem_addr, 32'h0000_0400);
    step();
    step();
    chk("b2b_pc", bus.inst_pc, 32'h0000_0400);

    // Alignment and address wrap
    redirect(32'h0000_0103, 1'b0, 32'h0);
    redirect(32'hFFFF_FFFC, 1'b0, 32'h0);
    step();
    chk("wrap_pc", bus.inst_pc, 32'h0);
    chk("wrap_data", bus.inst_data, c_mask);

    // Reset mid-stream, then backpressure from reset
    step();
    rst            = 1'b1;
    bus.inst_ready = 1'b0;
    step();
    chk("mr_req", bus.imem_req, 1'b0);
    chk("mr_valid", bus.inst_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk("bp_addr0", bus.imem_addr, 32'h0);
    for (int i = 1; i < 10; i++) begin
      step();
      chk("bp_req", bus.imem_req, (i < 4) ? 1'b1 : 1'b0);
      if (i < 4) chk("bp_addr", bus.imem_addr, 32'(4 * i));
      if (i >= 2) begin
        chk("bp_valid", bus.inst_valid, 1'b1);
        chk("bp_pc_hold", bus.inst_pc, 32'h0);
        chk("bp_data_hold", bus.inst_data, c_mask);
      end
    end
    step();
    bus.inst_ready = 1'b1;
    #1;
    chk("bp_full_noreq", bus.imem_req, 1'b0);
    chk("bp_pc0", bus.inst_pc, 32'h0);
    step();
    chk("bp_resume_req", bus.imem_req, 1'b1);
    chk("bp_resume_addr", bus.imem_addr, 32'h10);
    chk("bp_pc4", bus.inst_pc, 32'h4);
    step();
    chk("bp_pc8", bus.inst_pc, 32'h8);
    step();
    chk("bp_pcC", bus.inst_pc, 32'hC);
    step();
    chk("bp_pc10", bus.inst_pc, 32'h10);
    bus.inst_ready = 1'b0;

    // Fill the queue, then reset with it full
    repeat (6) step();
    chk("full_req", bus.imem_req, 1'b0);
    chk("full_head", bus.inst_pc, 32'h10);
    rst = 1'b1;
    step();
    chk("fr_valid", bus.inst_valid, 1'b0);
    chk("fr_req", bus.imem_req, 1'b0);
    chk("fr_pc", bus.inst_pc, 32'h0);
    rst = 1'b0;
    #1;
    chk("fr_req_after", bus.imem_req, 1'b1);
    chk("fr_addr_after", bus.imem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the CPU decode/execute datapath.
- Owns the fetch PC and issues sequential reads to a synchronous instruction ROM.
- Buffers returned instructions in a small prefetch queue and hands them to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump/exception target) from downstream, which flushes all speculative fetches.

Parameters:
- ADDR_W, 32, PC and ROM address width.
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, fetch address after reset.
- DEPTH, 4, prefetch queue entries (power of two, at least 2).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_req  out  1  ROM read strobe.
- imem_addr  out  ADDR_W  ROM byte address; equals the fetch PC.
- imem_rdata  in  DATA_W  ROM data, valid exactly 1 cycle after imem_req.
- inst_valid  out  1  queue head is valid.
- inst_ready  in  1  decode accepts the head.
- inst_data  out  DATA_W  instruction at queue head.
- inst_pc  out  ADDR_W  PC of inst_data.
- redirect_valid  in  1  flush and refetch.
- redirect_pc  in  ADDR_W  new fetch target.

Behaviour:
- Reset (synchronous, active-high; while rst=1 and in the cycle after):
  - fetch_pc = RESET_PC, queue count = 0, in-flight flag = 0, kill flag = 0.
  - imem_req = 0, inst_valid = 0, inst_data = 0, inst_pc = 0.
- Request issue:
  - imem_req = 1 when rst=0, redirect_valid=0 and count + inflight < DEPTH. This check is conservative: a same-cycle pop is not credited.
  - On issue: latch inflight_pc = fetch_pc, set inflight, and update fetch_pc <= fetch_pc + 4 (mod 2^ADDR_W, wraps silently).
- Response:
  - The cycle after an issue, {inflight_pc, imem_rdata} is pushed into the queue unless kill is set.
  - Inflight clears unless a new request is issued in that same cycle.
  - The queue can never overflow because of the credit rule.
- Output:
  - inst_valid = (count != 0); inst_data and inst_pc come from the registered queue head.
  - A transfer occurs when inst_valid && inst_ready, and pops the head.
  - While inst_valid=1 and inst_ready=0, inst_data and inst_pc hold stable.
- Latency:
  - Request to visible instruction: 2 cycles (issue at N, push at N+1, inst_valid at N+2).
  - Steady state with inst_ready=1: one instruction per cycle.
- Redirect (redirect_valid=1 in cycle R):
  - Queue is cleared at the end of R.
  - If a request is in flight, kill is set so its data arriving at R+1 is discarded.
  - fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}, i.e. low 2 bits forced to 0.
  - No request is issued in R. First request is at R+1; its instruction reaches inst_valid at R+3.
- Simultaneous redirect and handshake: the head transfer in cycle R completes (decode owns it); all other entries are discarded.
- Redirect in consecutive cycles: the last redirect wins, and each one kills any in-flight response.
- Simultaneous push and pop: count is unchanged and order is preserved.
- Reset mid-operation: the queue and in-flight data are discarded; the first post-reset request is RESET_PC.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - XLEN = 32.
  - RESET_PC.
  - INST_W.
  - PC_STEP = 4.
  - a fetch-entry typedef {pc, inst}.
- One sub-module, fetch_queue: a synchronous DEPTH-entry FIFO of fetch entries with push, pop, flush, count and head outputs.
- The top level holds the PC, the in-flight/kill tracking, the issue logic and the redirect handling.

Test Plan:
- Streaming: release rst at cycle 0, inst_ready=1, ROM returns data = addr ^ 32'hA5A5_0000 → imem_addr 0,4,8,… at cycles 0,1,2,…; inst_valid first at cycle 2 with inst_pc=0; then one instruction per cycle with matching data.
- Backpressure: hold inst_ready=0 from reset for 10 cycles → exactly 4 requests (0x0–0xC), then imem_req=0; inst_pc holds at 0 and inst_data is stable. Raise ready → instructions 0x0, 0x4, 0x8, 0xC, 0x10 in order, and requests resume at 0x10.
- Redirect with in-flight: during streaming, redirect_valid=1, redirect_pc=0x100 at cycle R → no imem_req at R; the ROM data returned at R+1 is never presented; imem_addr=0x100 at R+1; the next presented inst_pc is 0x100, at R+3.
- Redirect with handshake: redirect_pc=0x200 in the same cycle as inst_valid && inst_ready on pc 0x8 → pc 0x8 counts as consumed; the next presented inst_pc is 0x200 with no stale entries.
- Alignment and wrap: redirect_pc=0x103 → first fetch at 0x100. redirect_pc=0xFFFF_FFFC → fetches 0xFFFF_FFFC then 0x0000_0000.
- Mid-run reset: assert rst for 1 cycle with the queue full → the following cycle has inst_valid=0 and imem_req=0; after release the first imem_addr=RESET_PC.
